// File: rtl/tx_frame_ctrl_module_if.sv
// Byte-source / baud-counter / serial-line bundle for the UART TX framing controller.
// The controller sits on the slave side; whoever supplies bytes and strobes is the master.
interface tx_frame_ctrl_module_if;
  logic       TX_En_Sig;
  logic [7:0] TX_Data;
  logic       BPS_CLK;
  logic       Count_Sig;
  logic       TX_Pin_Out;
  logic       TX_Busy;
  logic       TX_Done_Sig;

  modport master (
    output TX_En_Sig, TX_Data, BPS_CLK,
    input  Count_Sig, TX_Pin_Out, TX_Busy, TX_Done_Sig
  );

  modport slave (
    input  TX_En_Sig, TX_Data, BPS_CLK,
    output Count_Sig, TX_Pin_Out, TX_Busy, TX_Done_Sig
  );
endinterface

// File: rtl/tx_frame_ctrl_module.sv
// UART transmit framing controller.
// Accepts one byte per request, enables the external baud counter through Count_Sig and
// walks start / data (LSB first) / optional parity / stop bits on TX_Pin_Out, stepping only
// on the mid-period BPS_CLK strobe. A one-cycle TX_Done_Sig marks the end of every frame.
module tx_frame_ctrl_module #(
  parameter int DATA_BITS = 8,   // 5..8
  parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input logic                   CLK,
  input logic                   RST,
  tx_frame_ctrl_module_if.slave tx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_DATA_BITS  = 4'(DATA_BITS);
  localparam logic [1:0] LP_STOP_BITS  = 2'(STOP_BITS);
  localparam bit         LP_HAS_PARITY = (PARITY != 0);
  localparam bit         LP_ODD        = (PARITY == 1);
  // Selects the data bits that actually go on the line; upper byte bits are ignored.
  localparam logic [7:0] LP_DATA_MASK  = 8'hFF >> (8 - DATA_BITS);

  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_parity;
  logic [3:0]             r_bit_cnt;
  logic [1:0]             r_stop_cnt;
  logic                   r_pin;
  logic                   r_count;
  logic                   r_busy;
  logic                   r_done;

  state_t                 w_state;
  logic [DATA_BITS-1:0]   w_shift;
  logic                   w_parity;
  logic [3:0]             w_bit_cnt;
  logic [1:0]             w_stop_cnt;
  logic                   w_pin;
  logic                   w_count;
  logic                   w_busy;
  logic                   w_done;

  logic [7:0]             w_data_masked;
  logic                   w_parity_calc;
  logic [DATA_BITS-1:0]   w_shift_out;

  assign w_data_masked = tx_if.TX_Data & LP_DATA_MASK;
  // Odd parity makes the total count of ones odd, even parity makes it even.
  assign w_parity_calc = LP_ODD ? ~(^w_data_masked) : (^w_data_masked);
  // The next data bit always sits in bit 0; shifting right brings the following one down.
  assign w_shift_out   = {1'b0, r_shift[DATA_BITS-1:1]};

  // State and output registers; every output leaves the block straight from a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_pin      <= 1'b1;
      r_count    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values together.
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_parity   <= w_parity;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_pin      <= w_pin;
      r_count    <= w_count;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  // Next-state and next-output logic; only IDLE->ARM and DONE->IDLE move without a strobe.
  always_comb begin
    // NOTE: hold-current defaults first, so no path through the case leaves a latch behind.
    w_state    = r_state;
    w_shift    = r_shift;
    w_parity   = r_parity;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    w_pin      = r_pin;
    w_count    = r_count;
    w_busy     = r_busy;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pin   = 1'b1;
        w_count = 1'b0;
        w_busy  = 1'b0;
        if (tx_if.TX_En_Sig) begin
          w_shift    = w_data_masked[DATA_BITS-1:0];
          w_parity   = w_parity_calc;
          w_bit_cnt  = '0;
          w_stop_cnt = '0;
          w_count    = 1'b1;
          w_busy     = 1'b1;
          w_state    = S_ARM;
        end
      end

      // Line stays high until the first mid-period strobe opens the start bit.
      S_ARM: begin
        if (tx_if.BPS_CLK) begin
          w_pin   = 1'b0;
          w_state = S_START;
        end
      end

      S_START: begin
        if (tx_if.BPS_CLK) begin
          w_pin     = r_shift[0];
          w_shift   = w_shift_out;
          w_bit_cnt = 4'd1;
          w_state   = S_DATA;
        end
      end

      S_DATA: begin
        if (tx_if.BPS_CLK) begin
          if (r_bit_cnt < LP_DATA_BITS) begin
            w_pin     = r_shift[0];
            w_shift   = w_shift_out;
            w_bit_cnt = r_bit_cnt + 4'd1;
          end else if (LP_HAS_PARITY) begin
            w_pin   = r_parity;
            w_state = S_PARITY;
          end else begin
            w_pin      = 1'b1;
            w_stop_cnt = 2'd1;
            w_state    = S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (tx_if.BPS_CLK) begin
          w_pin      = 1'b1;
          w_stop_cnt = 2'd1;
          w_state    = S_STOP;
        end
      end

      // The final strobe ends the last stop bit; the counter is released with the Done pulse.
      S_STOP: begin
        if (tx_if.BPS_CLK) begin
          if (r_stop_cnt < LP_STOP_BITS) begin
            w_stop_cnt = r_stop_cnt + 2'd1;
          end else begin
            w_count = 1'b0;
            w_done  = 1'b1;
            w_state = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_pin   = 1'b1;
        w_count = 1'b0;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end

      default: begin
        w_pin   = 1'b1;
        w_count = 1'b0;
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

  assign tx_if.Count_Sig   = r_count;
  assign tx_if.TX_Pin_Out  = r_pin;
  assign tx_if.TX_Busy     = r_busy;
  assign tx_if.TX_Done_Sig = r_done;

endmodule

// File: tb/tb_tx_frame_ctrl_module.sv
// Bench for tx_frame_ctrl_module: four instances (8N1, 8E1, 8O1, 7N2), each fed by a
// behavioural baud counter. Expected line levels come from a bit-list model of the frame.
module tb_tx_frame_ctrl_module;

  logic       CLK;
  logic       RST;
  logic [3:0] en;
  logic [3:0] xtra;
  logic [3:0] bps;
  logic [3:0] pin;
  logic [3:0] cnt_sig;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] data [4];

  int div       = 16;
  int cyc       = 0;
  int n_total   = 0;
  int n_pass    = 0;
  int done_cnt0 = 0;

  tx_frame_ctrl_module_if bus0 ();
  tx_frame_ctrl_module_if bus1 ();
  tx_frame_ctrl_module_if bus2 ();
  tx_frame_ctrl_module_if bus3 ();

  tx_frame_ctrl_module #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (.CLK(CLK), .RST(RST), .tx_if(bus0));
  tx_frame_ctrl_module #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (.CLK(CLK), .RST(RST), .tx_if(bus1));
  tx_frame_ctrl_module #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_8o1 (.CLK(CLK), .RST(RST), .tx_if(bus2));
  tx_frame_ctrl_module #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (.CLK(CLK), .RST(RST), .tx_if(bus3));

  assign bus0.TX_En_Sig = en[0];  assign bus0.TX_Data = data[0];  assign bus0.BPS_CLK = bps[0];
  assign bus1.TX_En_Sig = en[1];  assign bus1.TX_Data = data[1];  assign bus1.BPS_CLK = bps[1];
  assign bus2.TX_En_Sig = en[2];  assign bus2.TX_Data = data[2];  assign bus2.BPS_CLK = bps[2];
  assign bus3.TX_En_Sig = en[3];  assign bus3.TX_Data = data[3];  assign bus3.BPS_CLK = bps[3];

  assign pin     = {bus3.TX_Pin_Out,  bus2.TX_Pin_Out,  bus1.TX_Pin_Out,  bus0.TX_Pin_Out};
  assign cnt_sig = {bus3.Count_Sig,   bus2.Count_Sig,   bus1.Count_Sig,   bus0.Count_Sig};
  assign busy    = {bus3.TX_Busy,     bus2.TX_Busy,     bus1.TX_Busy,     bus0.TX_Busy};
  assign done    = {bus3.TX_Done_Sig, bus2.TX_Done_Sig, bus1.TX_Done_Sig, bus0.TX_Done_Sig};

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (done[0]) done_cnt0 <= done_cnt0 + 1;

  // Baud counter model: cleared while Count_Sig=0, strobes once per period at the half-way count.
  for (genvar g = 0; g < 4; g++) begin : g_baud
    int bcnt = 0;
    always @(posedge CLK) begin
      if (!cnt_sig[g])          bcnt <= 0;
      else if (bcnt == div - 1) bcnt <= 0;
      else                      bcnt <= bcnt + 1;
    end
    assign bps[g] = (cnt_sig[g] && (bcnt == div / 2)) || xtra[g];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sends one byte on instance d and checks every line level, bit timing and the Done pulse.
  task automatic run_frame(input int d, input logic [7:0] b, input int nbits, input int par,
                           input int nstop, input bit hold_en, input int poke_at, input string tag);
    logic exp_q[$];
    int   ones, frame_len, limit, n_str, t_last, gap, exp_gap, glitches;
    logic prev_bps, last_lvl, seen_done, poke_active, pbit;

    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (par != 0) begin
      pbit = ((ones % 2) == 1);
      if (par == 1) pbit = !pbit;
      exp_q.push_back(pbit);
    end
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
    frame_len = 1 + nbits + ((par != 0) ? 1 : 0) + nstop + 1;

    data[d] = b;
    en[d]   = 1'b1;
    limit   = 0;
    while (cnt_sig[d] !== 1'b1 && limit < 50) begin
      @(negedge CLK);
      limit++;
    end
    n_total++;
    if (limit !== 1) begin
      $display("FAIL %s accept: Count_Sig rose after %0d cycles, want 1", tag, limit);
      en[d] = hold_en;
      return;
    end else n_pass++;
    if (!hold_en) en[d] = 1'b0;

    t_last      = cyc;
    n_str       = 0;
    glitches    = 0;
    last_lvl    = 1'b1;
    prev_bps    = bps[d];
    seen_done   = 1'b0;
    poke_active = 1'b0;
    limit       = (frame_len + 2) * div + 50;
    for (int c = 0; c < limit && !seen_done; c++) begin
      @(negedge CLK);
      if (poke_active) begin
        en[d]       = hold_en;
        poke_active = 1'b0;
      end
      if (prev_bps) begin
        n_str++;
        gap     = cyc - t_last;
        exp_gap = (n_str == 1) ? (div / 2 + 1) : div;
        t_last  = cyc;
        n_total++;
        if (gap < exp_gap - 1 || gap > exp_gap + 1)
          $display("FAIL %s timing strobe%0d: %0d cycles, want %0d+-1", tag, n_str, gap, exp_gap);
        else n_pass++;
        if (n_str <= exp_q.size()) begin
          n_total++;
          if (pin[d] !== exp_q[n_str-1])
            $display("FAIL %s level%0d: got %b want %b", tag, n_str - 1, pin[d], exp_q[n_str-1]);
          else n_pass++;
        end
        last_lvl = pin[d];
        if (n_str == poke_at) begin
          data[d]     = ~b;
          en[d]       = 1'b1;
          poke_active = 1'b1;
        end
      end else if (pin[d] !== last_lvl) glitches++;
      if (done[d] === 1'b1) seen_done = 1'b1;
      prev_bps = bps[d];
    end

    n_total++;
    if (glitches !== 0) $display("FAIL %s hold: %0d level changes between strobes, want 0", tag, glitches);
    else n_pass++;
    n_total++;
    if (!seen_done) begin
      $display("FAIL %s done: no Done pulse within %0d cycles", tag, limit);
      return;
    end else n_pass++;
    n_total++;
    if (n_str !== frame_len) $display("FAIL %s length: Done after strobe %0d, want %0d", tag, n_str, frame_len);
    else n_pass++;
    n_total++;
    if (cnt_sig[d] !== 1'b0 || busy[d] !== 1'b1 || pin[d] !== 1'b1)
      $display("FAIL %s done-state: count=%b busy=%b pin=%b want 0 1 1", tag, cnt_sig[d], busy[d], pin[d]);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (done[d] !== 1'b0 || busy[d] !== 1'b0 || pin[d] !== 1'b1)
      $display("FAIL %s after-done: done=%b busy=%b pin=%b want 0 0 1", tag, done[d], busy[d], pin[d]);
    else n_pass++;
  endtask

  task automatic test_reset();
    int bad;
    RST  = 1'b1;
    en   = 4'hF;
    bad  = 0;
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      xtra = (i % 3 == 0) ? 4'hF : 4'h0;
      if (pin !== 4'hF || cnt_sig !== 4'h0 || busy !== 4'h0 || done !== 4'h0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL reset_hold: %0d bad cycles (pin=%b cnt=%b busy=%b done=%b)", bad, pin, cnt_sig, busy, done);
    else n_pass++;
    en   = 4'h0;
    xtra = 4'h0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    n_total++;
    if (pin !== 4'hF || cnt_sig !== 4'h0 || busy !== 4'h0 || done !== 4'h0)
      $display("FAIL reset_release: pin=%b cnt=%b busy=%b done=%b want F 0 0 0", pin, cnt_sig, busy, done);
    else n_pass++;
  endtask

  task automatic test_8n1_real_baud();
    div = 5208;
    run_frame(0, 8'hA5, 8, 0, 1, 1'b0, 0, "8n1_a5");
    div = 16;
  endtask

  task automatic test_parity();
    run_frame(1, 8'h07, 8, 2, 1, 1'b0, 0, "even_07");
    run_frame(2, 8'h07, 8, 1, 1, 1'b0, 0, "odd_07");
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 8'($urandom), 8, 2, 1, 1'b0, 0, "even_rand");
      run_frame(2, 8'($urandom), 8, 1, 1, 1'b0, 0, "odd_rand");
    end
  endtask

  task automatic test_7n2();
    run_frame(3, 8'hFF, 7, 0, 2, 1'b0, 0, "7n2_ff");
    run_frame(3, 8'($urandom), 7, 0, 2, 1'b0, 0, "7n2_rand");
  endtask

  task automatic test_midframe_request();
    int bad;
    run_frame(0, 8'($urandom), 8, 0, 1, 1'b0, 4, "midframe");
    bad = 0;
    for (int i = 0; i < 4 * div; i++) begin
      @(negedge CLK);
      if (cnt_sig[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL midframe_no_second: %0d busy cycles after frame, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int start;
    start = done_cnt0;
    for (int i = 0; i < 3; i++) run_frame(0, 8'($urandom), 8, 0, 1, 1'b1, 0, "b2b");
    en[0] = 1'b0;
    repeat (3 * div) @(negedge CLK);
    n_total++;
    if (done_cnt0 - start !== 3) $display("FAIL b2b_done_count: got %0d want 3", done_cnt0 - start);
    else n_pass++;
    n_total++;
    if (busy[0] !== 1'b0 || cnt_sig[0] !== 1'b0) $display("FAIL b2b_stop: busy=%b count=%b want 0 0", busy[0], cnt_sig[0]);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int   n, bad, limit;
    logic prev;
    data[0] = 8'($urandom) & 8'hEF;
    en[0]   = 1'b1;
    limit   = 0;
    while (cnt_sig[0] !== 1'b1 && limit < 50) begin
      @(negedge CLK);
      limit++;
    end
    en[0] = 1'b0;
    n     = 0;
    prev  = bps[0];
    for (int c = 0; c < 20 * div && n < 6; c++) begin
      @(negedge CLK);
      if (prev) n++;
      prev = bps[0];
    end
    n_total++;
    if (n !== 6) $display("FAIL rst_mid_reach: saw %0d strobes, want 6", n);
    else n_pass++;
    repeat (4) @(negedge CLK);
    n_total++;
    if (pin[0] !== 1'b0) $display("FAIL rst_mid_bit4: line=%b want 0", pin[0]);
    else n_pass++;
    #3 RST = 1'b1;
    #1;
    n_total++;
    if (pin[0] !== 1'b1 || cnt_sig[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0)
      $display("FAIL rst_mid_abort: pin=%b count=%b busy=%b done=%b want 1 0 0 0", pin[0], cnt_sig[0], busy[0], done[0]);
    else n_pass++;
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (done !== 4'h0 || pin !== 4'hF) bad++;
    end
    RST = 1'b0;
    repeat (4 * div) begin
      @(negedge CLK);
      if (done !== 4'h0 || busy !== 4'h0) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL rst_mid_quiet: %0d cycles with Done/busy after abort, want 0", bad);
    else n_pass++;
    run_frame(0, 8'h3C, 8, 0, 1, 1'b0, 0, "after_rst_3c");
  endtask

  initial begin
    RST  = 1'b1;
    en   = 4'h0;
    xtra = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    test_reset();
    test_8n1_real_baud();
    test_parity();
    test_7n2();
    test_midframe_request();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tx_frame_ctrl_module.md
Name: tx_frame_ctrl_module

Overview:
UART transmit framing controller for the serial TX path. It accepts one byte per request from the upstream Modbus/PS2 byte source and enables the TX baud-rate counter through Count_Sig. It consumes the mid-bit BPS_CLK strobe from that counter to step through the start bit, data bits (LSB first), optional parity and stop bits on TX_Pin_Out. It pulses TX_Done_Sig when the frame completes, so the byte sequencer can issue the next byte.

Parameters:
DATA_BITS, 8, number of data bits per frame; legal values 5..8; uses TX_Data[DATA_BITS-1:0].
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
CLK  in  1  system clock, 50 MHz.
RST  in  1  asynchronous, active-high reset.
TX_En_Sig  in  1  transmit request; sampled only in IDLE.
TX_Data  in  8  byte to send; latched on acceptance.
BPS_CLK  in  1  one-cycle bit strobe from the baud counter; arrives mid-period while Count_Sig=1.
Count_Sig  out  1  enables the baud counter; 0 clears it.
TX_Pin_Out  out  1  serial line; idle high.
TX_Busy  out  1  high in every state except IDLE.
TX_Done_Sig  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, RST=1): state=IDLE; TX_Pin_Out=1, Count_Sig=0, TX_Busy=0, TX_Done_Sig=0; shift register and bit counter cleared. Reset mid-frame aborts the frame immediately, with no Done pulse.
- All outputs are registered. The FSM advances only on BPS_CLK=1, except for IDLE->ARM and DONE->IDLE.
- IDLE: if TX_En_Sig=1, latch TX_Data into the shift register, compute the parity bit from the latched data (odd: XOR of data bits inverted; even: XOR of data bits), and go to ARM. Count_Sig=1 from the next cycle.
- ARM: TX_Pin_Out stays 1 and waits for the first BPS_CLK.
  - On BPS_CLK: TX_Pin_Out<=0 and go to START.
- START: on BPS_CLK, TX_Pin_Out<=data[0], bit count<=1, go to DATA.
- DATA: on each BPS_CLK:
  - If bit count<DATA_BITS, output the next bit and increment the count.
  - Else output parity and go to PARITY (when PARITY!=0), or output 1 and go to STOP (when PARITY=0).
- PARITY: on BPS_CLK, TX_Pin_Out<=1 and go to STOP with stop count=1.
- STOP: on BPS_CLK:
  - If stop count<STOP_BITS, hold 1 and increment the count.
  - Else go to DONE with Count_Sig<=0.
- DONE: lasts one cycle. TX_Done_Sig=1, TX_Busy=1, Count_Sig=0. Then go to IDLE.
- Each line level is held between consecutive BPS_CLK strobes, so each bit lasts one full baud period (5208 CLK at 9600 Bd).
- The start bit begins at the first strobe, about half a period after Count_Sig rises.
- Frame length in strobes is 1 + DATA_BITS + (PARITY!=0) + STOP_BITS + 1. For 8N1 that is 11 strobes.
- Handshake rules:
  - TX_En_Sig is ignored while TX_Busy=1; it is not queued.
  - TX_Data changes after acceptance do not affect the frame.
  - Earliest back-to-back acceptance is the first IDLE cycle after DONE. The line then stays high until the next first strobe, giving an inter-frame gap of at least half a period.
- A BPS_CLK strobe while in IDLE or DONE is ignored.
- TX_En_Sig asserted continuously sends frames back-to-back, one accepted per IDLE visit.

Test Plan:
- Reset: hold RST=1 with TX_En_Sig=1 and strobes applied -> TX_Pin_Out=1, Count_Sig=0, TX_Busy=0, TX_Done_Sig=0 throughout; nothing is accepted.
- 8N1 with the real baud counter at 50 MHz: send 0xA5. The line must fall 2605±1 cycles after Count_Sig rises and then show bits 0,1,0,1,0,0,1,0,1,1 with each bit lasting 5208±1 cycles. TX_Done_Sig is exactly one cycle, 5208±1 cycles after the stop bit starts.
- PARITY=2 (even), TX_Data=0x07 -> parity bit=1. PARITY=1 (odd), same data -> parity bit=0. Frame length is 12 strobes.
- STOP_BITS=2, DATA_BITS=7, TX_Data=0xFF -> 7 ones, then the line stays high for 2 periods, and Done follows after strobe 11.
- Change TX_Data and pulse TX_En_Sig mid-frame -> the frame is unchanged and no second frame starts. With TX_En_Sig held high, 3 frames go out back-to-back with 3 Done pulses.
- Assert RST during data bit 4 -> TX_Pin_Out=1 and Count_Sig=0 in the same cycle, with no Done pulse. After release, a new 0x3C request transmits correctly.
